// File: rtl/dram_raster_writer_pkg.sv
// Shared defaults and FSM encoding for the DRAM raster writer.
package dram_pkg;
  localparam int DEF_D_WIDTH   = 8;
  localparam int DEF_A_WIDTH   = 21;
  localparam int DEF_IMG_W     = 1280;
  localparam int DEF_IMG_H     = 720;
  localparam int PIX_PER_FRAME = DEF_IMG_W * DEF_IMG_H;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} wr_state_e;
endpackage

// File: rtl/dram_raster_writer_addr_gen.sv
// Raster x/y walker with a linear DRAM address; flags the final pixel of the frame.
module raster_addr_gen #(
  parameter int A_WIDTH = 21,
  parameter int IMG_W   = 1280,
  parameter int IMG_H   = 720
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [A_WIDTH-1:0] base_addr,
  output logic [A_WIDTH-1:0] addr,
  output logic               last
);
  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          x_end;

  assign x_end = (x == X_LAST);
  assign last  = x_end && (y == Y_LAST);

  // addr wraps naturally at 2^A_WIDTH
  always_ff @(posedge clk) begin
    if (rst) begin
      x    <= '0;
      y    <= '0;
      addr <= '0;
    end else if (load) begin
      x    <= '0;
      y    <= '0;
      addr <= base_addr;
    end else if (step) begin
      addr <= addr + A_WIDTH'(1);
      if (x_end) begin
        x <= '0;
        y <= last ? '0 : y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end
  end
endmodule

// File: rtl/dram_raster_writer.sv
// Streams one frame into a byte-wide DRAM write port, yielding to the read side.
// Optional DRAM_WR_CKSUM_EN adds a 16-bit sum of retired write data.
module dram_raster_writer import dram_pkg::*; #(
  parameter int D_WIDTH = DEF_D_WIDTH,
  parameter int A_WIDTH = DEF_A_WIDTH,
  parameter int IMG_W   = DEF_IMG_W,
  parameter int IMG_H   = DEF_IMG_H
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [A_WIDTH-1:0] base_addr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [D_WIDTH-1:0] in_data,
  input  logic               rd_busy,
  output logic               wen,
  output logic [A_WIDTH-1:0] waddr,
  output logic [D_WIDTH-1:0] wdata,
  output logic               busy,
  output logic               done
`ifdef DRAM_WR_CKSUM_EN
  ,output logic [15:0]       cksum
`endif
);
  wr_state_e          state, state_nxt;
  logic               pend, accept, load, last, done_nxt;
  logic [A_WIDTH-1:0] addr;

  // reads win the DRAM port, so a pending write only issues when the read side is quiet
  assign wen      = pend && !rd_busy;
  assign in_ready = (state == RUN) && (!pend || wen);
  assign accept   = in_valid && in_ready;
  assign load     = (state == IDLE) && start;
  assign busy     = (state != IDLE);

  raster_addr_gen #(
    .A_WIDTH (A_WIDTH),
    .IMG_W   (IMG_W),
    .IMG_H   (IMG_H)
  ) u_agen (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .step      (accept),
    .base_addr (base_addr),
    .addr      (addr),
    .last      (last)
  );

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    unique case (state)
      IDLE:  if (start) state_nxt = RUN;
      RUN:   if (accept && last) state_nxt = FLUSH;
      FLUSH: if (!pend || wen) begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
    end
  end

  // single-entry holding register; a same-cycle accept overrides the retire
  always_ff @(posedge clk) begin
    if (rst) begin
      pend  <= 1'b0;
      waddr <= '0;
      wdata <= '0;
    end else if (accept) begin
      pend  <= 1'b1;
      waddr <= addr;
      wdata <= in_data;
    end else if (wen) begin
      pend  <= 1'b0;
    end
  end

`ifdef DRAM_WR_CKSUM_EN
  always_ff @(posedge clk) begin
    if (rst || load) cksum <= '0;
    else if (wen)    cksum <= cksum + 16'(wdata);
  end
`endif
endmodule

// File: tb/tb_dram_raster_writer.sv
// Bench for dram_raster_writer on a 4x2 frame: directed table, corner sequences, random vs queue model.
module tb_dram_raster_writer;
  localparam int DW = 8;
  localparam int AW = 21;
  localparam int P  = 8;

  logic          clk, rst, start, in_valid, in_ready, rd_busy, wen, busy, done;
  logic [AW-1:0] base_addr, waddr;
  logic [DW-1:0] in_data, wdata;
`ifdef DRAM_WR_CKSUM_EN
  logic [15:0]   cksum;
`endif

  dram_raster_writer #(.D_WIDTH(DW), .A_WIDTH(AW), .IMG_W(4), .IMG_H(2)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .rd_busy(rd_busy),
    .wen(wen), .waddr(waddr), .wdata(wdata), .busy(busy), .done(done)
`ifdef DRAM_WR_CKSUM_EN
    , .cksum(cksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  bit chk_en = 0;

  // reference: frame progress as a pixel count plus a queue of writes not yet retired
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  wr_t           pq[$];
  bit            m_active, m_done;
  int            m_n;
  logic [AW-1:0] m_base;
  logic [15:0]   m_sum;
  int            n_wr, n_done;
  logic [AW-1:0] first_wa, last_wa;

  typedef struct {
    logic st; logic iv; logic [DW-1:0] d; logic rb;
    logic rdy; logic we; logic [AW-1:0] wa; logic [DW-1:0] wd; logic bz; logic dn;
  } vec_t;
  vec_t tbl[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic model_step();
    logic e_wen, e_rdy, acc;
    e_wen = (pq.size() > 0) && !rd_busy;
    e_rdy = m_active && (m_n < P) && (pq.size() == 0 || e_wen);
    if (chk_en) begin
      chk("wen", wen, e_wen);
      chk("in_ready", in_ready, e_rdy);
      chk("busy", busy, m_active);
      chk("done", done, m_done);
      if (e_wen) begin
        chk("waddr", waddr, pq[0].a);
        chk("wdata", wdata, pq[0].d);
      end
`ifdef DRAM_WR_CKSUM_EN
      chk("cksum", cksum, m_sum);
`endif
    end
    if (wen === 1'b1) begin
      if (n_wr == 0) first_wa = waddr;
      last_wa = waddr;
      n_wr++;
    end
    if (done === 1'b1) n_done++;
    acc = in_valid && e_rdy;
    if (rst) begin
      pq.delete();
      m_active = 0; m_done = 0; m_n = 0; m_sum = '0;
    end else begin
      m_done = 0;
      if (e_wen) begin
        m_sum = m_sum + 16'(pq[0].d);
        void'(pq.pop_front());
      end
      if (acc) begin
        pq.push_back('{a: AW'(m_base + AW'(m_n)), d: in_data});
        m_n++;
      end
      if (m_active && m_n == P && pq.size() == 0) begin
        m_active = 0;
        m_done   = 1;
      end else if (!m_active && start) begin
        m_active = 1; m_n = 0; m_base = base_addr; m_sum = '0;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int busy_run;
    bit got;
    rst = 1; start = 0; base_addr = '0; in_valid = 0; in_data = '0; rd_busy = 0;
    m_active = 0; m_done = 0; m_n = 0; m_base = '0; m_sum = '0;
    n_wr = 0; n_done = 0; first_wa = '0; last_wa = '0; busy_run = 0;
    tick();
    chk_en = 1;
    tick();
    rst = 0;

    // wrap-around frame: stall of two cycles, a bubble, a start during RUN, stall in FLUSH
    tbl[0]  = '{1,0,8'h00,0, 0,0,21'h000000,8'h00,0,0};
    tbl[1]  = '{0,1,8'h10,0, 1,0,21'h000000,8'h00,1,0};
    tbl[2]  = '{0,1,8'h11,0, 1,1,21'h1FFFFE,8'h10,1,0};
    tbl[3]  = '{0,1,8'h12,1, 0,0,21'h1FFFFF,8'h11,1,0};
    tbl[4]  = '{0,1,8'h12,1, 0,0,21'h1FFFFF,8'h11,1,0};
    tbl[5]  = '{0,1,8'h12,0, 1,1,21'h1FFFFF,8'h11,1,0};
    tbl[6]  = '{0,0,8'h00,0, 1,1,21'h000000,8'h12,1,0};
    tbl[7]  = '{1,1,8'h13,0, 1,0,21'h000000,8'h12,1,0};
    tbl[8]  = '{0,1,8'h14,0, 1,1,21'h000001,8'h13,1,0};
    tbl[9]  = '{0,1,8'h15,0, 1,1,21'h000002,8'h14,1,0};
    tbl[10] = '{0,1,8'h16,0, 1,1,21'h000003,8'h15,1,0};
    tbl[11] = '{0,1,8'h17,0, 1,1,21'h000004,8'h16,1,0};
    tbl[12] = '{0,1,8'h18,1, 0,0,21'h000005,8'h17,1,0};
    tbl[13] = '{0,1,8'h18,0, 0,1,21'h000005,8'h17,1,0};
    tbl[14] = '{0,0,8'h00,0, 0,0,21'h000005,8'h17,0,1};
    tbl[15] = '{0,0,8'h00,0, 0,0,21'h000005,8'h17,0,0};
    base_addr = 21'h1FFFFE;
    for (int i = 0; i < 16; i++) begin
      start = tbl[i].st; in_valid = tbl[i].iv; in_data = tbl[i].d; rd_busy = tbl[i].rb;
      @(negedge clk);
      chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].rdy);
      chk($sformatf("tbl%0d_wen", i), wen, tbl[i].we);
      chk($sformatf("tbl%0d_waddr", i), waddr, tbl[i].wa);
      chk($sformatf("tbl%0d_wdata", i), wdata, tbl[i].wd);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].bz);
      chk($sformatf("tbl%0d_done", i), done, tbl[i].dn);
      model_step();
      @(posedge clk);
      #1;
    end
    start = 0; in_valid = 0; rd_busy = 0;

    // input bubbles 1010...
    base_addr = 21'h40; start = 1;
    tick();
    start = 0; n_wr = 0; n_done = 0;
    for (int i = 0; i < 30; i++) begin
      in_valid = (i % 2 == 0); in_data = 8'($urandom);
      tick();
    end
    in_valid = 0;
    chk("bubble_writes", n_wr, 8);
    chk("bubble_dones", n_done, 1);
    chk("bubble_first_addr", first_wa, 21'h40);
    chk("bubble_last_addr", last_wa, 21'h47);

    // reset after three accepts
    base_addr = 21'h100; start = 1;
    tick();
    start = 0; in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'(i + 1);
      tick();
    end
    rst = 1;
    tick();
    rst = 0;
    @(negedge clk);
    chk("midrst_wen", wen, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 0);
    model_step();
    @(posedge clk);
    #1;
    in_valid = 0;

`ifdef DRAM_WR_CKSUM_EN
    rst = 1;
    tick();
    rst = 0; base_addr = '0; start = 1;
    tick();
    start = 0; in_valid = 1; in_data = 8'hFF;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (done) begin
        chk("cksum_at_done", cksum, 16'h07F8);
        got = 1;
      end
      model_step();
      @(posedge clk);
      #1;
    end
    if (!got) chk("cksum_done_seen", 0, 1);
    in_valid = 0;
`else
    got = 0;
`endif

    // random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rst   = ($urandom_range(0, 399) == 0);
      start = ($urandom_range(0, 5) == 0);
      base_addr = ($urandom_range(0, 3) == 0) ? 21'h1FFFFF - 21'($urandom_range(0, 6))
                                               : 21'($urandom);
      in_valid = ($urandom_range(0, 9) < 7);
      in_data  = 8'($urandom);
      if (busy_run == 0 && $urandom_range(0, 9) == 0) busy_run = $urandom_range(1, 6);
      rd_busy = (busy_run > 0);
      if (busy_run > 0) busy_run--;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
